// File: rtl/alu_arb_ctrl.sv
// Two-requester sequencer/arbiter around a shared combinational 8-bit ALU (bit_8alu).
// Optional per-requester accumulators are built when ALU_ARB_ACC_EN is defined.

module bit_8alu (
    input  logic [3:0] i_op,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_y,
    output logic       o_cout
);
    logic [8:0] w_r;

    always_comb begin
        w_r = 9'd0;
        case (i_op)
            4'b0000: w_r = {1'b0, i_a} + {1'b0, i_b};
            4'b0001: w_r = {1'b0, i_a} - {1'b0, i_b};
            4'b0010: w_r = {1'b0, i_a & i_b};
            4'b0011: w_r = {1'b0, i_a | i_b};
            4'b0101: w_r = {1'b0, i_a ^ i_b};
            4'b0110: w_r = {1'b0, ~i_a};
            4'b0111: w_r = {1'b0, i_a} + 9'd1;
            default: w_r = 9'd0;
        endcase
    end

    assign o_y    = w_r[7:0];
    assign o_cout = w_r[8];
endmodule

module alu_arb_ctrl #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [3:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req0_acc,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic       req1_acc,
    output logic       req1_ready,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_y,
    output logic       rsp0_cout,
    output logic       rsp0_zero,
    output logic       rsp0_err,
    input  logic       rsp0_ready,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_y,
    output logic       rsp1_cout,
    output logic       rsp1_zero,
    output logic       rsp1_err,
    input  logic       rsp1_ready
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t     r_state;
    logic       r_prio;
    logic       r_owner;
    logic [3:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [1:0] r_vld;
    logic [7:0] r_y [2];
    logic [1:0] r_cout;
    logic [1:0] r_zero;
    logic [1:0] r_err;

    logic       w_grant;
    logic       w_accept;
    logic [3:0] w_op_in;
    logic [7:0] w_a_raw;
    logic [7:0] w_a_in;
    logic [7:0] w_b_in;
    logic       w_acc_in;
    logic [1:0] w_rsp_rdy;
    logic       w_done;
    logic [7:0] w_alu_y;
    logic       w_alu_cout;
    logic       w_err;
    logic       w_arith;
    logic [7:0] w_res_y;

    // Priority only matters when both requesters are valid at once.
    assign w_grant    = (req0_valid & req1_valid) ? r_prio : req1_valid;
    assign req0_ready = (r_state == S_IDLE) & req0_valid & ~w_grant;
    assign req1_ready = (r_state == S_IDLE) & req1_valid &  w_grant;
    assign w_accept   = req0_ready | req1_ready;

    assign w_op_in  = w_grant ? req1_op  : req0_op;
    assign w_a_raw  = w_grant ? req1_a   : req0_a;
    assign w_b_in   = w_grant ? req1_b   : req0_b;
    assign w_acc_in = w_grant ? req1_acc : req0_acc;

    assign w_rsp_rdy = {rsp1_ready, rsp0_ready};
    assign w_done    = (r_state == S_RESP) & r_vld[r_owner] & w_rsp_rdy[r_owner];

`ifdef ALU_ARB_ACC_EN
    logic [7:0] r_acc [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc[0] <= 8'h00;
            r_acc[1] <= 8'h00;
        end else if (w_done) begin
            r_acc[r_owner] <= r_y[r_owner];
        end
    end

    assign w_a_in = w_acc_in ? r_acc[w_grant] : w_a_raw;
`else
    logic w_unused_acc;
    assign w_unused_acc = w_acc_in;
    assign w_a_in       = w_a_raw;
`endif

    // Operands are pure data; only the accept strobe qualifies them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op <= w_op_in;
            r_a  <= w_a_in;
            r_b  <= w_b_in;
        end
    end

    bit_8alu u_alu (
        .i_op   (r_op),
        .i_a    (r_a),
        .i_b    (r_b),
        .o_y    (w_alu_y),
        .o_cout (w_alu_cout)
    );

    assign w_err   = r_op[3] | (r_op == 4'b0100);
    assign w_arith = (r_op == 4'b0000) | (r_op == 4'b0001) | (r_op == 4'b0111);
    assign w_res_y = w_err ? 8'h00 : w_alu_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_prio  <= PRIO_INIT;
            r_owner <= 1'b0;
            r_vld   <= 2'b00;
            r_y[0]  <= 8'h00;
            r_y[1]  <= 8'h00;
            r_cout  <= 2'b00;
            r_zero  <= 2'b00;
            r_err   <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_grant;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_y[r_owner]    <= w_res_y;
                    r_cout[r_owner] <= w_arith & w_alu_cout;
                    r_zero[r_owner] <= (w_res_y == 8'h00);
                    r_err[r_owner]  <= w_err;
                    r_vld[r_owner]  <= 1'b1;
                    r_state         <= S_RESP;
                end
                S_RESP: begin
                    if (w_done) begin
                        r_vld   <= 2'b00;
                        r_prio  <= ~r_owner;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp0_valid = r_vld[0];
    assign rsp0_y     = r_y[0];
    assign rsp0_cout  = r_cout[0];
    assign rsp0_zero  = r_zero[0];
    assign rsp0_err   = r_err[0];
    assign rsp1_valid = r_vld[1];
    assign rsp1_y     = r_y[1];
    assign rsp1_cout  = r_cout[1];
    assign rsp1_zero  = r_zero[1];
    assign rsp1_err   = r_err[1];
endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Randomized bench for alu_arb_ctrl against a transaction-level reference model.
// Honors ALU_ARB_ACC_EN the same way the design does.

module tb_alu_arb_ctrl;
    localparam logic PRIO_INIT = 1'b0;
`ifdef ALU_ARB_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0] req0_op = '0, req1_op = '0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_acc = 1'b0, req1_acc = 1'b0;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_y, rsp1_y;
    logic       rsp0_cout, rsp0_zero, rsp0_err;
    logic       rsp1_cout, rsp1_zero, rsp1_err;
    logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;

    alu_arb_ctrl #(.PRIO_INIT(PRIO_INIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_acc(req0_acc), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_acc(req1_acc), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_y(rsp0_y), .rsp0_cout(rsp0_cout),
        .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_y(rsp1_y), .rsp1_cout(rsp1_cout),
        .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err), .rsp1_ready(rsp1_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: pending requests, priority holder, accumulators.
    bit         p_v   [2];
    logic [3:0] p_op  [2];
    logic [7:0] p_a   [2];
    logic [7:0] p_b   [2];
    bit         p_acc [2];
    int         m_prio;
    int         m_acc [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // {err, zero, cout, y[7:0]} from plain integer arithmetic
    function automatic logic [10:0] ref_alu(input logic [3:0] op, input int a, input int b);
        int  y = 0;
        bit  cout = 0;
        bit  err = 0;
        case (op)
            4'd0: begin y = (a + b) % 256; cout = (a + b) > 255; end
            4'd1: begin y = (a - b + 256) % 256; cout = a < b; end
            4'd2: y = a & b;
            4'd3: y = a | b;
            4'd5: y = a ^ b;
            4'd6: y = 255 - a;
            4'd7: begin y = (a + 1) % 256; cout = (a + 1) > 255; end
            default: err = 1;
        endcase
        return {err, (y == 0), cout, 8'(y)};
    endfunction

    function automatic logic [11:0] rsp_of(input int n);
        if (n == 0) return {rsp0_valid, rsp0_err, rsp0_zero, rsp0_cout, rsp0_y};
        return {rsp1_valid, rsp1_err, rsp1_zero, rsp1_cout, rsp1_y};
    endfunction

    function automatic logic rsp_vld_of(input int n);
        return (n == 0) ? rsp0_valid : rsp1_valid;
    endfunction

    task automatic drive_reqs();
        req0_valid = p_v[0]; req0_op = p_op[0]; req0_a = p_a[0]; req0_b = p_b[0]; req0_acc = p_acc[0];
        req1_valid = p_v[1]; req1_op = p_op[1]; req1_a = p_a[1]; req1_b = p_b[1]; req1_acc = p_acc[1];
    endtask

    task automatic set_req(input int n, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input bit acc);
        p_v[n] = 1'b1; p_op[n] = op; p_a[n] = a; p_b[n] = b; p_acc[n] = acc;
    endtask

    task automatic new_req(input int n);
        set_req(n, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        drive_reqs();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset_outputs",
            {req0_ready, req1_ready, rsp0_valid, rsp0_y, rsp0_cout, rsp0_zero, rsp0_err,
             rsp1_valid, rsp1_y, rsp1_cout, rsp1_zero, rsp1_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_prio = int'(PRIO_INIT);
        m_acc[0] = 0; m_acc[1] = 0;
    endtask

    // One transaction starting in IDLE at a negedge; bp<0 picks random backpressure.
    task automatic run_round(input bit abort, input int bp, input bit raise_other, output int g);
        int          o, ea, nbp;
        logic [10:0] e;
        drive_reqs();
        #1;
        g = (p_v[0] && p_v[1]) ? m_prio : (p_v[1] ? 1 : 0);
        o = 1 - g;
        chk("ready0_idle", req0_ready, p_v[0] && g == 0);
        chk("ready1_idle", req1_ready, p_v[1] && g == 1);
        ea = (ACC_EN && p_acc[g]) ? m_acc[g] : int'(p_a[g]);
        e  = ref_alu(p_op[g], ea, int'(p_b[g]));
        @(posedge clk);
        @(negedge clk);
        p_v[g] = 1'b0;
        drive_reqs();
        #1;
        chk("exec_rsp_vld", {rsp0_valid, rsp1_valid}, 2'b00);
        chk("exec_ready", {req0_ready, req1_ready}, 2'b00);
        if (abort) begin
            do_reset();
            return;
        end
        @(negedge clk);
        #1;
        chk("rsp_owner", rsp_of(g), {1'b1, e});
        chk("rsp_other_vld", rsp_vld_of(o), 1'b0);
        nbp = (bp < 0) ? $urandom_range(0, 3) : bp;
        for (int i = 0; i < nbp; i++) begin
            @(negedge clk);
            if (!p_v[o] && (raise_other || (bp < 0 && $urandom_range(0, 1) == 1))) new_req(o);
            drive_reqs();
            if (o == 0) rsp0_ready = 1'($urandom); else rsp1_ready = 1'($urandom);
            #1;
            chk("hold_rsp", rsp_of(g), {1'b1, e});
            chk("hold_no_accept", {req0_ready, req1_ready}, 2'b00);
        end
        @(negedge clk);
        if (g == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        chk("rsp_cleared", {rsp0_valid, rsp1_valid}, 2'b00);
        m_prio = o;
        m_acc[g] = int'(e[7:0]);
    endtask

    task automatic drain();
        int g;
        while (p_v[0] || p_v[1]) run_round(1'b0, 0, 1'b0, g);
    endtask

    initial begin
        int g;
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        p_op[0] = '0; p_op[1] = '0; p_a[0] = '0; p_a[1] = '0;
        p_b[0] = '0; p_b[1] = '0; p_acc[0] = 1'b0; p_acc[1] = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        set_req(0, 4'b0000, 8'hF0, 8'h20, 1'b0);
        run_round(1'b0, 0, 1'b0, g);
        set_req(1, 4'b0001, 8'h05, 8'h05, 1'b0);
        run_round(1'b0, 1, 1'b0, g);
        set_req(1, 4'b0001, 8'h03, 8'h05, 1'b0);
        run_round(1'b0, 0, 1'b0, g);

        for (int i = 0; i < 6; i++) begin
            if (!p_v[0]) new_req(0);
            if (!p_v[1]) new_req(1);
            run_round(1'b0, 0, 1'b0, g);
            chk("alternate_grant", 32'(g), 32'(i % 2));
        end
        drain();

        set_req(0, 4'b1010, 8'h5A, 8'hA5, 1'b0);
        run_round(1'b0, 5, 1'b1, g);
        drain();

        set_req(0, 4'b0000, 8'h11, 8'h22, 1'b0);
        run_round(1'b1, 0, 1'b0, g);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("no_stale_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        end
        new_req(0); new_req(1);
        run_round(1'b0, 0, 1'b0, g);
        chk("prio_after_reset", 32'(g), 32'(PRIO_INIT));
        drain();

        do_reset();
        set_req(0, 4'b0111, 8'h7F, 8'h00, 1'b0);
        run_round(1'b0, 0, 1'b0, g);
        set_req(0, 4'b0111, 8'h00, 8'h00, 1'b1);
        run_round(1'b0, 0, 1'b0, g);
        set_req(1, 4'b0111, 8'h55, 8'h00, 1'b1);
        run_round(1'b0, 0, 1'b0, g);

        for (int r = 0; r < 200; r++) begin
            if (!p_v[0] && $urandom_range(0, 1) == 1) new_req(0);
            if (!p_v[1] && $urandom_range(0, 1) == 1) new_req(1);
            if (!p_v[0] && !p_v[1]) new_req($urandom_range(0, 1));
            run_round(1'b0, -1, 1'b0, g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
